// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures operand A, operand B and a 4-bit opcode from one switch bank,
// one field per press of a single load button. The raw button is synchronised, debounced and
// turned into a one-cycle load pulse that steps a 4-state sequencer.
// Optional build macro: LOADER_DEBOUNCE_BYPASS_EN removes the debounce counter so that every
// synchronised rising edge counts as one press.

module alu_operand_loader #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] switches,
  input  logic         load_btn,
  output logic [N-1:0] entrada1,
  output logic [N-1:0] entrada2,
  output logic [3:0]   selector,
  output logic         valid,
  output logic [1:0]   stage
);

  typedef enum logic [1:0] {
    StLoadA  = 2'b00,
    StLoadB  = 2'b01,
    StLoadOp = 2'b10,
    StShow   = 2'b11
  } state_e;

  logic sync1_q;
  logic btn_s_q;
  logic deb_q;
  logic load_pulse_q;

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= load_btn;
      btn_s_q <= sync1_q;
    end
  end

`ifdef LOADER_DEBOUNCE_BYPASS_EN

  // Debounce removed: deb follows btn_s one cycle later, pulse on each synchronised rise
  always_ff @(posedge clock) begin
    if (!reset) begin
      deb_q        <= 1'b0;
      load_pulse_q <= 1'b0;
    end else begin
      deb_q        <= btn_s_q;
      load_pulse_q <= btn_s_q & ~deb_q;
    end
  end

`else

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_d;
  logic            deb_prev_q;

  // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles in a row;
  // any return to the old level clears the count
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (btn_s_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = btn_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and registered rising-edge detector on deb
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q        <= '0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      load_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      load_pulse_q <= deb_q & ~deb_prev_q;
    end
  end

`endif

  state_e state_q, state_d;
  logic   cap_a, cap_b, cap_op;
  logic   valid_d;

  // Sequencer: advance one field per load pulse, select which field to capture
  always_comb begin
    state_d = state_q;
    cap_a   = 1'b0;
    cap_b   = 1'b0;
    cap_op  = 1'b0;
    valid_d = 1'b0;
    if (load_pulse_q) begin
      unique case (state_q)
        StLoadA: begin
          state_d = StLoadB;
          cap_a   = 1'b1;
        end
        StLoadB: begin
          state_d = StLoadOp;
          cap_b   = 1'b1;
        end
        StLoadOp: begin
          state_d = StShow;
          cap_op  = 1'b1;
          valid_d = 1'b1;
        end
        StShow: begin
          state_d = StLoadA;
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  // State and captured-field registers; fields hold until overwritten
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StLoadA;
      entrada1 <= '0;
      entrada2 <= '0;
      selector <= '0;
      valid    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= valid_d;
      if (cap_a)  entrada1 <= switches;
      if (cap_b)  entrada2 <= switches;
      if (cap_op) selector <= switches[3:0];
    end
  end

  assign stage = state_q;

endmodule
